// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. A pixel-rate enable is derived
//   from the system clock by an integer divider. Horizontal and vertical
//   position counters advance on that enable. Sync, blank and frame-start
//   flags are registered from the next counter values, so they always
//   describe the (DrawX, DrawY) pair currently presented.
//
// Ports
//   Clk         in   system clock, all state on rising edge
//   Reset_n     in   asynchronous active-low reset
//   pixel_ce    out  one-Clk pulse per pixel period
//   DrawX       out  [9:0] current horizontal count
//   DrawY       out  [9:0] current vertical count
//   hs          out  horizontal sync, active-low
//   vs          out  vertical sync, active-low
//   blank       out  1 = visible region, 0 = blanking
//   frame_start out  one-Clk pulse when (DrawX, DrawY) wraps to (0,0)

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // A divide-by-1 build still needs a one-bit divider register; it simply
    // stays at zero, which equals its terminal value every cycle.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             advance;
    logic             x_wrap;
    logic             y_wrap;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    always_comb begin
        advance = (div_cnt == DIV_MAX);
        x_wrap  = (DrawX == H_LAST);
        y_wrap  = (DrawY == V_LAST);
        x_next  = DrawX;
        y_next  = DrawY;
        if (advance) begin
            if (x_wrap) begin
                x_next = 10'd0;
                y_next = y_wrap ? 10'd0 : DrawY + 10'd1;
            end else begin
                x_next = DrawX + 10'd1;
            end
        end
    end

    // Flags are computed from x_next/y_next so they change on the same edge
    // as the counters and never lag them by a cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt     <= '0;
            pixel_ce    <= 1'b0;
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= advance ? '0 : div_cnt + DIV_W'(1);
            pixel_ce    <= advance;
            DrawX       <= x_next;
            DrawY       <= y_next;
            hs          <= !((x_next >= H_SYNC_START) && (x_next < H_SYNC_END));
            vs          <= !((y_next >= V_SYNC_START) && (y_next < V_SYNC_END));
            blank       <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_start <= advance && x_wrap && y_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Two instances share one clock:
//   dut_a keeps the default horizontal timing with CLK_DIV=2 and a short
//   11-line frame (4 visible, fp 2, sync 2, bp 3), giving 800*11*2 = 17600
//   Clk cycles per frame.
//   dut_b is a CLK_DIV=1 build with a 17x9 raster, giving 153 Clk cycles per
//   frame.

module tb_vga_timing_gen;

    localparam int LIMIT = 20000;

    logic       Clk = 1'b0;
    logic       ra_n = 1'b1;
    logic       rb_n = 1'b1;

    logic       pce_a, hs_a, vs_a, blank_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       pce_b, hs_b, vs_b, blank_b, fs_b;
    logic [9:0] x_b, y_b;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    vga_timing_gen #(
        .V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(3), .CLK_DIV(2)
    ) dut_a (
        .Clk(Clk), .Reset_n(ra_n), .pixel_ce(pce_a), .DrawX(x_a), .DrawY(y_a),
        .hs(hs_a), .vs(vs_a), .blank(blank_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(1)
    ) dut_b (
        .Clk(Clk), .Reset_n(rb_n), .pixel_ce(pce_b), .DrawX(x_b), .DrawY(y_b),
        .hs(hs_b), .vs(vs_b), .blank(blank_b), .frame_start(fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".pce"}, 32'(pce_a), 32'd0);
        chk({tag, ".x"}, 32'(x_a), 32'd0);
        chk({tag, ".y"}, 32'(y_a), 32'd0);
        chk({tag, ".hs"}, 32'(hs_a), 32'd1);
        chk({tag, ".vs"}, 32'(vs_a), 32'd1);
        chk({tag, ".blank"}, 32'(blank_a), 32'd1);
        chk({tag, ".fs"}, 32'(fs_a), 32'd0);
    endtask

    task automatic wait_xa(input logic [9:0] tgt);
        int n = 0;
        while (x_a !== tgt && n < LIMIT) begin
            tick(1);
            n++;
        end
        chk("wait_x", 32'(x_a), 32'(tgt));
    endtask

    task automatic wait_ya(input logic [9:0] tgt);
        int n = 0;
        while (y_a !== tgt && n < 2 * LIMIT) begin
            tick(1);
            n++;
        end
        chk("wait_y", 32'(y_a), 32'(tgt));
    endtask

    initial begin
        int n;
        int len;
        logic pce_b_gap;

        // Asynchronous reset assertion before any clock edge.
        #2;
        ra_n = 1'b0;
        rb_n = 1'b0;
        #1;
        chk_reset_a("rst0");
        chk("rst0.b.pce", 32'(pce_b), 32'd0);
        chk("rst0.b.x", 32'(x_b), 32'd0);
        chk("rst0.b.fs", 32'(fs_b), 32'd0);

        // Release between edges; first edge after release is at t=25.
        #19;
        ra_n = 1'b1;
        rb_n = 1'b1;

        tick(1);
        chk("rel.e1.pce", 32'(pce_a), 32'd0);
        chk("rel.e1.x", 32'(x_a), 32'd0);
        chk("rel.e1.fs", 32'(fs_a), 32'd0);
        chk("rel.e1.b.pce", 32'(pce_b), 32'd1);
        chk("rel.e1.b.x", 32'(x_b), 32'd1);
        tick(1);
        chk("rel.e2.pce", 32'(pce_a), 32'd1);
        chk("rel.e2.x", 32'(x_a), 32'd1);
        chk("rel.e2.fs", 32'(fs_a), 32'd0);
        tick(1);
        chk("rel.e3.pce", 32'(pce_a), 32'd0);
        chk("rel.e3.x", 32'(x_a), 32'd1);
        tick(1);
        chk("rel.e4.pce", 32'(pce_a), 32'd1);
        chk("rel.e4.x", 32'(x_a), 32'd2);
        chk("rel.e4.y", 32'(y_a), 32'd0);

        // Line timing at default horizontal parameters.
        wait_xa(10'd639);
        chk("line.639.blank", 32'(blank_a), 32'd1);
        wait_xa(10'd640);
        chk("line.640.blank", 32'(blank_a), 32'd0);
        chk("line.640.hs", 32'(hs_a), 32'd1);
        wait_xa(10'd655);
        chk("line.655.hs", 32'(hs_a), 32'd1);
        wait_xa(10'd656);
        chk("line.656.hs", 32'(hs_a), 32'd0);
        wait_xa(10'd751);
        chk("line.751.hs", 32'(hs_a), 32'd0);
        wait_xa(10'd752);
        chk("line.752.hs", 32'(hs_a), 32'd1);
        wait_xa(10'd799);
        chk("line.799.y", 32'(y_a), 32'd0);
        wait_xa(10'd0);
        chk("line.wrap.y", 32'(y_a), 32'd1);
        chk("line.wrap.pce", 32'(pce_a), 32'd1);
        chk("line.wrap.blank", 32'(blank_a), 32'd1);

        // Vertical timing: visible 0..3, sync on lines 6 and 7.
        wait_ya(10'd3);
        chk("frm.y3.blank", 32'(blank_a), 32'd1);
        wait_ya(10'd4);
        chk("frm.y4.blank", 32'(blank_a), 32'd0);
        chk("frm.y4.vs", 32'(vs_a), 32'd1);
        wait_ya(10'd5);
        chk("frm.y5.vs", 32'(vs_a), 32'd1);
        wait_ya(10'd6);
        chk("frm.y6.vs", 32'(vs_a), 32'd0);
        chk("frm.y6.blank", 32'(blank_a), 32'd0);
        wait_ya(10'd7);
        chk("frm.y7.vs", 32'(vs_a), 32'd0);
        wait_ya(10'd8);
        chk("frm.y8.vs", 32'(vs_a), 32'd1);
        chk("frm.y8.blank", 32'(blank_a), 32'd0);
        wait_xa(10'd100);
        chk("frm.y8x100.blank", 32'(blank_a), 32'd0);

        // Frame wrap (799,10) -> (0,0).
        n = 0;
        while (fs_a !== 1'b1 && n < 2 * LIMIT) begin
            tick(1);
            n++;
        end
        chk("wrap.fs", 32'(fs_a), 32'd1);
        chk("wrap.x", 32'(x_a), 32'd0);
        chk("wrap.y", 32'(y_a), 32'd0);
        chk("wrap.blank", 32'(blank_a), 32'd1);
        chk("wrap.hs", 32'(hs_a), 32'd1);
        chk("wrap.vs", 32'(vs_a), 32'd1);
        chk("wrap.pce", 32'(pce_a), 32'd1);
        tick(1);
        chk("wrap.fs.next", 32'(fs_a), 32'd0);

        // Frame length: 800 * 11 * 2 Clk cycles between frame_start pulses.
        len = 1;
        while (fs_a !== 1'b1 && len < 2 * LIMIT) begin
            tick(1);
            len++;
        end
        chk("frame.len.a", 32'(len), 32'd17600);

        // Async reset in the middle of horizontal sync, between edges.
        wait_xa(10'd700);
        chk("ares.pre.hs", 32'(hs_a), 32'd0);
        #2;
        ra_n = 1'b0;
        #1;
        chk_reset_a("ares");
        tick(2);
        chk_reset_a("ares.hold");
        #1;
        ra_n = 1'b1;
        tick(1);
        chk("ares.e1.x", 32'(x_a), 32'd0);
        chk("ares.e1.pce", 32'(pce_a), 32'd0);
        tick(1);
        chk("ares.e2.x", 32'(x_a), 32'd1);
        chk("ares.e2.y", 32'(y_a), 32'd0);
        chk("ares.e2.pce", 32'(pce_a), 32'd1);
        chk("ares.e2.fs", 32'(fs_a), 32'd0);

        // CLK_DIV=1 build: continuous pixel_ce and a 17*9 = 153 cycle frame.
        n = 0;
        while (fs_b !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        chk("b.wrap.fs", 32'(fs_b), 32'd1);
        chk("b.wrap.x", 32'(x_b), 32'd0);
        chk("b.wrap.y", 32'(y_b), 32'd0);
        chk("b.wrap.vs", 32'(vs_b), 32'd1);
        pce_b_gap = 1'b0;
        len = 0;
        do begin
            tick(1);
            len++;
            if (pce_b !== 1'b1) pce_b_gap = 1'b1;
        end while (fs_b !== 1'b1 && len < 400);
        chk("b.frame.len", 32'(len), 32'd153);
        chk("b.pce.gap", 32'(pce_b_gap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 2, Clk cycles per pixel (>=1)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk, in, 1, single system clock; all state on rising edge
- Reset_n, in, 1, asynchronous active-low reset
- pixel_ce, out, 1, one-Clk pulse per pixel period
- DrawX, out, 10, current horizontal count
- DrawY, out, 10, current vertical count
- hs, out, 1, horizontal sync, active-low
- vs, out, 1, vertical sync, active-low
- blank, out, 1, 1 = visible region, 0 = blanking
- frame_start, out, 1, one-Clk pulse at each frame wrap

REQ-003 The design SHALL use one clock and an asynchronous, active-low reset, with ports named Clk and Reset_n.

Function
REQ-004 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL equal V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
REQ-005 A divider counter SHALL count 0..CLK_DIV-1, wrapping to 0 after CLK_DIV-1.
REQ-006 pixel_ce SHALL be a register set to 1 for exactly one Clk cycle when the divider equals CLK_DIV-1, and 0 otherwise.
REQ-007 When CLK_DIV=1, pixel_ce SHALL be 1 every cycle after the first post-reset edge.
REQ-008 DrawX SHALL increment by 1 on each Clk edge on which the divider equals CLK_DIV-1; DrawX and DrawY SHALL hold otherwise.
REQ-009 When DrawX=H_TOTAL-1 at an advance, DrawX SHALL wrap to 0 and DrawY SHALL increment by 1.
REQ-010 When DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1 at an advance, both SHALL wrap to 0 on the same edge.
REQ-011 hs, vs, blank and frame_start SHALL be registered and updated on the same edge as DrawX/DrawY, so that they always describe the (DrawX, DrawY) values currently presented (zero-cycle skew).
REQ-012 hs SHALL be 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (default 656..751).
REQ-013 vs SHALL be 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (default 490..491).
REQ-014 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-015 frame_start SHALL be 1 for exactly one Clk cycle, the cycle in which (DrawX, DrawY) has just wrapped from (H_TOTAL-1, V_TOTAL-1) to (0,0); it SHALL NOT assert on exit from reset.
REQ-016 Counter arithmetic SHALL be unsigned 10-bit, and DrawX/DrawY SHALL never exceed H_TOTAL-1/V_TOTAL-1.

Reset
REQ-017 Assertion of Reset_n=0 SHALL immediately, without waiting for a Clk edge, force divider=0, DrawX=0, DrawY=0, pixel_ce=0, hs=1, vs=1, blank=1, frame_start=0.
REQ-018 Reset asserted mid-line or mid-sync SHALL abandon the frame, and after release counting SHALL restart from (0,0), with the first pixel_ce occurring CLK_DIV edges after release.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset release, CLK_DIV=2: pixel_ce high on edges 2, 4, 6, ...; DrawX reads 1 after edge 2 and 2 after edge 4; frame_start stays 0.
- Line timing: hs falls when DrawX=656, rises when DrawX=752; blank falls when DrawX=640; DrawY increments when DrawX wraps 799->0.
- Frame timing: vs low only for DrawY=490 and 491; blank=0 for all DrawY>=480; each frame is exactly 800*525*2 = 840000 Clk cycles.
- Frame wrap: at (799,524)->(0,0), frame_start=1 for one cycle, coincident with blank=1, hs=1, vs=1.
- Async reset with Reset_n=0 at DrawX=700 (hs=0) and no Clk edge: outputs reach their reset values within the same cycle; after release, counting resumes from (0,0).
- CLK_DIV=1 build: pixel_ce is constantly 1 after reset, and the frame is 420000 Clk cycles.
